lightbike_engine: RTL and testbench
===================================

// Module: lightbike_engine
// PURPOSE
//   Parametrised N-player light-cycle game engine. Owns the trail grid, player heads/directions, step timing,
//   collision resolution (wall, trail, head-on, swap), round/match scoring and a read-only display port for the VGA path.
//   Sits between keyboard/button decode (start/ack/turn pulses) and the VGA pixel generator.
// PARAMETERS
//   GRID_W      32        grid width in cells (>=8); XW = $clog2(GRID_W)
//   GRID_H      32        grid height in cells (>=8); YW = $clog2(GRID_H)
//   NUM_PLAYERS 2         players, 2..4; OW = $clog2(NUM_PLAYERS+1), PW = $clog2(NUM_PLAYERS)
//   TICK_DIV    2**22     board_clk cycles per game step; must be >= 2*NUM_PLAYERS+4
//   MAX_SCORE   9         round wins that end the match (<=15)
// PORTS
//   board_clk   in   1            system clock
//   reset       in   1            async, active-high
//   start       in   1            level/pulse: IDLE->CLEAR, READY->RUN
//   ack         in   1            acknowledge ROUND_OVER / MATCH_OVER
//   turn_left   in   N            per-player turn-left request pulse
//   turn_right  in   N            per-player turn-right request pulse
//   disp_x      in   XW           display read column
//   disp_y      in   YW           display read row
//   disp_owner  out  OW           cell owner at (disp_x,disp_y), 0=empty, p+1=player p; 1-cycle latency
//   disp_wall   out  1            cell is border; same 1-cycle latency
//   head_x      out  N*XW         player p head column at [p*XW +: XW]
//   head_y      out  N*YW         player p head row
//   alive       out  N            player alive mask
//   state       out  6            one-hot {MATCH_OVER,ROUND_OVER,RUN,READY,CLEAR,IDLE}
//   winner      out  PW           last round winner (valid in ROUND_OVER/MATCH_OVER when draw=0)
//   draw        out  1            last round had no survivor
//   score       out  N*4          per-player round wins at [p*4 +: 4]
//   step_pulse  out  1            1-cycle pulse when a step's positions commit
// BEHAVIOUR
//   Reset: state=IDLE, heads=0, alive=0, winner=0, draw=0, score=0, step_pulse=0, disp_* regs 0, turn latches 0.
//   Dir encoding 0=E(+x) 1=N(-y) 2=W(-x) 3=S(+y); left = dir+1 mod 4, right = dir-1 mod 4.
//   Start positions: p0 (2,H/2) E; p1 (W-3,H/2) W; p2 (W/2,2) S; p3 (W/2,H-3) N.
//   IDLE: start -> CLEAR. CLEAR: write 0 to every cell, raster order, 1 cell/cycle (W*H cycles); last cycle loads
//     start heads/dirs, alive=all-ones, draw=0 -> READY. READY: start -> RUN, tick counter cleared.
//   RUN: tick counter counts TICK_DIV cycles then launches a step; turn pulses set sticky per-player latches
//     (left and right both set = no turn); latches applied and cleared at step launch. Step sub-sequence:
//     MARK  N cycles: write grid[head_p]=p+1 for alive p (trail includes current heads).
//     PROBE N+1 cycles: read grid at next_p (sync read, result 1 cycle later).
//     RESOLVE 1 cycle: p dies if next_p is border, read cell !=0, or next_p equals another alive player's next_p.
//       Survivors move to next_p; dead heads freeze; step_pulse=1.
//     Swap (two heads exchanging cells) dies via occupied check. Next-pos computed at full width; x/y beyond border
//     never wraps (border check precedes move). Dead players issue no writes.
//   Round end (after RESOLVE): alive count 0 -> draw=1; count 1 -> winner=index, score[winner]+=1; else stay RUN.
//     If new score == MAX_SCORE -> MATCH_OVER else ROUND_OVER.
//   ROUND_OVER: ack -> CLEAR (scores kept). MATCH_OVER: ack -> scores=0 -> CLEAR. start ignored outside IDLE/READY.
//   Display port B independent of game port; disp_wall = x==0||x==W-1||y==0||y==H-1; disp_x >= W returns 0/0.
//   Reset mid-operation: immediate IDLE; grid contents undefined until next CLEAR completes.
// STRUCTURE
//   lightbike_defs.vh: direction codes, one-hot state codes, start-position/dir functions.
//   Sub-module lightbike_grid_ram: true dual-port W*H x OW RAM, port A r/w (engine), port B read (display),
//   synchronous read, 1-cycle latency. Engine FSM, tick counter, step sequencer, scoring in this module.
// TESTING (W=H=16, N=2, TICK_DIV=16, MAX_SCORE=2)
//   1 reset; start pulse -> CLEAR for 256 cycles -> READY, head0=(2,8) head1=(13,8), alive=2'b11.
//   2 start, no turns -> after 5 steps head0.x=7 head1.x=8; step 6 swap -> alive=0, draw=1, ROUND_OVER, scores 0.
//   3 new round, turn_left[0] before first tick -> p0 north y 8->1, step 8 hits y=0: alive=2'b10, winner=1, score1=1.
//   4 turn_left[1] and turn_right[1] in same step -> dir1 unchanged; disp read (2,8) after step 1 -> owner 1, 1 cycle later.
//   5 p1 wins a second round -> score1=2, MATCH_OVER; ack -> score=0, CLEAR.
//   6 reset asserted mid-RUN step -> state IDLE same cycle (async), alive=0, step_pulse=0.

Source files
------------

// File: rtl/lightbike_pkg.sv
// Shared codes for the light-cycle engine: directions, one-hot states, round start layout.
package lightbike_pkg;
    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_N = 2'd1;
    localparam logic [1:0] DIR_W = 2'd2;
    localparam logic [1:0] DIR_S = 2'd3;

    localparam logic [5:0] S_IDLE       = 6'b000001;
    localparam logic [5:0] S_CLEAR      = 6'b000010;
    localparam logic [5:0] S_READY      = 6'b000100;
    localparam logic [5:0] S_RUN        = 6'b001000;
    localparam logic [5:0] S_ROUND_OVER = 6'b010000;
    localparam logic [5:0] S_MATCH_OVER = 6'b100000;

    function automatic int start_x(input int p, input int w);
        case (p)
            0:       return 2;
            1:       return w - 3;
            default: return w / 2;
        endcase
    endfunction

    function automatic int start_y(input int p, input int h);
        case (p)
            0, 1:    return h / 2;
            2:       return 2;
            default: return h - 3;
        endcase
    endfunction

    function automatic logic [1:0] start_dir(input int p);
        case (p)
            0:       return DIR_E;
            1:       return DIR_W;
            2:       return DIR_S;
            default: return DIR_N;
        endcase
    endfunction
endpackage

// File: rtl/lightbike_grid_ram.sv
// Trail grid storage: port A read/write for the engine, port B read-only for the display.
module lightbike_grid_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 2
) (
    input  logic          board_clk,
    input  logic [AW-1:0] a_addr,
    input  logic          a_we,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Read-first on port A; both reads have one cycle of latency.
    always_ff @(posedge board_clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_addr];
    end
endmodule

// File: rtl/lightbike_engine.sv
// N-player light-cycle engine: round FSM, step timing, MARK/PROBE/RESOLVE step sequencer, scoring.
module lightbike_engine
    import lightbike_pkg::*;
#(
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 32,
    parameter int NUM_PLAYERS = 2,
    parameter int TICK_DIV    = 2**22,
    parameter int MAX_SCORE   = 9,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int OW = $clog2(NUM_PLAYERS + 1),
    localparam int PW = $clog2(NUM_PLAYERS)
) (
    input  logic                        board_clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        ack,
    input  logic [NUM_PLAYERS-1:0]      turn_left,
    input  logic [NUM_PLAYERS-1:0]      turn_right,
    input  logic [XW-1:0]               disp_x,
    input  logic [YW-1:0]               disp_y,
    output logic [OW-1:0]               disp_owner,
    output logic                        disp_wall,
    output logic [NUM_PLAYERS*XW-1:0]   head_x,
    output logic [NUM_PLAYERS*YW-1:0]   head_y,
    output logic [NUM_PLAYERS-1:0]      alive,
    output logic [5:0]                  state,
    output logic [PW-1:0]               winner,
    output logic                        draw,
    output logic [NUM_PLAYERS*4-1:0]    score,
    output logic                        step_pulse
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int AW    = $clog2(CELLS);
    localparam int TW    = $clog2(TICK_DIV);
    localparam int PHW   = $clog2(2 * NUM_PLAYERS + 2);
    localparam int XEW   = XW + 1;
    localparam int YEW   = YW + 1;

    logic [5:0]                          st;
    logic [NUM_PLAYERS-1:0][XW-1:0]      hx;
    logic [NUM_PLAYERS-1:0][YW-1:0]      hy;
    logic [NUM_PLAYERS-1:0][1:0]         dir;
    logic [NUM_PLAYERS-1:0][3:0]         sc;
    logic [NUM_PLAYERS-1:0][OW-1:0]      occ;
    logic [NUM_PLAYERS-1:0][XEW-1:0]     nx;
    logic [NUM_PLAYERS-1:0][YEW-1:0]     ny;
    logic [NUM_PLAYERS-1:0]              tl_q, tr_q, border, hit, alive_nx;
    logic [OW-1:0]                       alive_cnt;
    logic [PW-1:0]                       win_idx;
    logic [AW-1:0]                       clr_addr, a_addr;
    logic                                a_we;
    logic [OW-1:0]                       a_wdata, a_rdata, b_rdata;
    logic [TW-1:0]                       tick;
    logic                                stepping;
    logic [PHW-1:0]                      ph;
    logic                                disp_ok_q, disp_wall_q;

    function automatic logic [AW-1:0] addr_of(input logic [XEW-1:0] x, input logic [YEW-1:0] y);
        return AW'(32'(y) * GRID_W + 32'(x));
    endfunction

    // Next positions carry one extra bit so a border step is detected before any wrap.
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            nx[p] = {1'b0, hx[p]};
            ny[p] = {1'b0, hy[p]};
            case (dir[p])
                DIR_E:   nx[p] = nx[p] + 1'b1;
                DIR_N:   ny[p] = ny[p] - 1'b1;
                DIR_W:   nx[p] = nx[p] - 1'b1;
                default: ny[p] = ny[p] + 1'b1;
            endcase
            border[p] = (nx[p] == '0) || (nx[p] >= XEW'(GRID_W - 1)) ||
                        (ny[p] == '0) || (ny[p] >= YEW'(GRID_H - 1));
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            hit[p] = border[p] || (occ[p] != '0);
            for (int q = 0; q < NUM_PLAYERS; q++)
                if (q != p && alive[q] && nx[q] == nx[p] && ny[q] == ny[p]) hit[p] = 1'b1;
        end
        alive_nx  = alive & ~hit;
        alive_cnt = '0;
        win_idx   = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (alive_nx[p]) begin
                alive_cnt = alive_cnt + OW'(1);
                win_idx   = PW'(p);
            end
    end

    always_comb begin
        a_addr  = '0;
        a_we    = 1'b0;
        a_wdata = '0;
        if (st == S_CLEAR) begin
            a_addr = clr_addr;
            a_we   = 1'b1;
        end else if (stepping) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (int'(ph) == p) begin
                    a_addr  = addr_of({1'b0, hx[p]}, {1'b0, hy[p]});
                    a_we    = alive[p];
                    a_wdata = OW'(p + 1);
                end
                if (int'(ph) == NUM_PLAYERS + p) a_addr = addr_of(nx[p], ny[p]);
            end
        end
    end

    lightbike_grid_ram #(.DEPTH(CELLS), .AW(AW), .DW(OW)) u_grid (
        .board_clk (board_clk),
        .a_addr    (a_addr),
        .a_we      (a_we),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .b_addr    (addr_of({1'b0, disp_x}, {1'b0, disp_y})),
        .b_rdata   (b_rdata)
    );

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            st <= S_IDLE;  hx <= '0;  hy <= '0;  dir <= '0;  sc <= '0;  occ <= '0;
            alive <= '0;  winner <= '0;  draw <= 1'b0;  step_pulse <= 1'b0;
            tl_q <= '0;  tr_q <= '0;  clr_addr <= '0;  tick <= '0;  stepping <= 1'b0;  ph <= '0;
            disp_ok_q <= 1'b0;  disp_wall_q <= 1'b0;
        end else begin
            step_pulse  <= 1'b0;
            disp_ok_q   <= (int'(disp_x) < GRID_W) && (int'(disp_y) < GRID_H);
            disp_wall_q <= (int'(disp_x) < GRID_W) && (int'(disp_y) < GRID_H) &&
                           (disp_x == '0 || disp_x == XW'(GRID_W - 1) ||
                            disp_y == '0 || disp_y == YW'(GRID_H - 1));
            case (st)
                S_IDLE: if (start) begin
                    st       <= S_CLEAR;
                    clr_addr <= '0;
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == AW'(CELLS - 1)) begin
                        for (int p = 0; p < NUM_PLAYERS; p++) begin
                            hx[p]  <= XW'(start_x(p, GRID_W));
                            hy[p]  <= YW'(start_y(p, GRID_H));
                            dir[p] <= start_dir(p);
                        end
                        alive    <= '1;
                        draw     <= 1'b0;
                        clr_addr <= '0;
                        st       <= S_READY;
                    end
                end
                S_READY: if (start) begin
                    st       <= S_RUN;
                    tick     <= '0;
                    stepping <= 1'b0;
                    tl_q     <= '0;
                    tr_q     <= '0;
                end
                S_RUN: begin
                    tl_q <= tl_q | turn_left;
                    tr_q <= tr_q | turn_right;
                    if (stepping) begin
                        ph <= ph + 1'b1;
                        for (int p = 0; p < NUM_PLAYERS; p++)
                            if (int'(ph) == NUM_PLAYERS + 1 + p) occ[p] <= a_rdata;
                        if (int'(ph) == 2 * NUM_PLAYERS + 1) begin
                            stepping   <= 1'b0;
                            step_pulse <= 1'b1;
                            alive      <= alive_nx;
                            for (int p = 0; p < NUM_PLAYERS; p++)
                                if (alive_nx[p]) begin
                                    hx[p] <= nx[p][XW-1:0];
                                    hy[p] <= ny[p][YW-1:0];
                                end
                            if (alive_cnt == '0) begin
                                draw <= 1'b1;
                                st   <= S_ROUND_OVER;
                            end else if (alive_cnt == OW'(1)) begin
                                winner      <= win_idx;
                                sc[win_idx] <= sc[win_idx] + 4'd1;
                                st <= (sc[win_idx] == 4'(MAX_SCORE - 1)) ? S_MATCH_OVER : S_ROUND_OVER;
                            end
                        end
                    end
                    // Latched turns apply at launch; pulses arriving that same cycle carry to the next step.
                    if (tick == TW'(TICK_DIV - 1)) begin
                        tick     <= '0;
                        stepping <= 1'b1;
                        ph       <= '0;
                        for (int p = 0; p < NUM_PLAYERS; p++)
                            if (tl_q[p] && !tr_q[p])      dir[p] <= dir[p] + 2'd1;
                            else if (tr_q[p] && !tl_q[p]) dir[p] <= dir[p] - 2'd1;
                        tl_q <= turn_left;
                        tr_q <= turn_right;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                S_ROUND_OVER: if (ack) st <= S_CLEAR;
                S_MATCH_OVER: if (ack) begin
                    sc <= '0;
                    st <= S_CLEAR;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    assign state      = st;
    assign head_x     = hx;
    assign head_y     = hy;
    assign score      = sc;
    assign disp_owner = disp_ok_q ? b_rdata : '0;
    assign disp_wall  = disp_wall_q;
endmodule

// File: tb/tb_lightbike_engine.sv
// Directed bench for lightbike_engine on a 16x16 grid, two players, short tick.
module tb_lightbike_engine;
    localparam logic [5:0] ST_IDLE  = 6'b000001, ST_CLEAR = 6'b000010, ST_READY = 6'b000100;
    localparam logic [5:0] ST_RUN   = 6'b001000, ST_ROUND = 6'b010000, ST_MATCH = 6'b100000;

    logic       board_clk, reset, start, ack;
    logic [1:0] turn_left, turn_right;
    logic [3:0] disp_x, disp_y;
    logic [1:0] disp_owner;
    logic       disp_wall;
    logic [7:0] head_x, head_y;
    logic [1:0] alive;
    logic [5:0] state;
    logic [0:0] winner;
    logic       draw;
    logic [7:0] score;
    logic       step_pulse;

    int n_vec = 0;
    int n_bad = 0;

    lightbike_engine #(.GRID_W(16), .GRID_H(16), .NUM_PLAYERS(2), .TICK_DIV(16), .MAX_SCORE(2)) dut (
        .board_clk(board_clk), .reset(reset), .start(start), .ack(ack),
        .turn_left(turn_left), .turn_right(turn_right), .disp_x(disp_x), .disp_y(disp_y),
        .disp_owner(disp_owner), .disp_wall(disp_wall), .head_x(head_x), .head_y(head_y),
        .alive(alive), .state(state), .winner(winner), .draw(draw), .score(score),
        .step_pulse(step_pulse)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] owner;
        logic       wall;
    } dvec_t;
    dvec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int which);
        if (which == 0) start = 1'b1; else ack = 1'b1;
        @(negedge board_clk);
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic wait_state(input logic [5:0] s, input string name);
        int k = 0;
        while (state !== s && k < 600) begin
            @(negedge board_clk);
            k++;
        end
        if (state !== s) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout, state %0h want %0h", name, state, s);
        end
    endtask

    task automatic wait_step(input string name, output int k);
        k = 0;
        do begin
            @(negedge board_clk);
            k++;
        end while (step_pulse !== 1'b1 && k < 200);
        if (step_pulse !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout waiting for step_pulse", name);
        end
    endtask

    initial begin
        int n;
        tbl[0]  = '{4'd2,  4'd8,  2'd1, 1'b0};
        tbl[1]  = '{4'd7,  4'd8,  2'd1, 1'b0};
        tbl[2]  = '{4'd8,  4'd8,  2'd2, 1'b0};
        tbl[3]  = '{4'd13, 4'd8,  2'd2, 1'b0};
        tbl[4]  = '{4'd14, 4'd8,  2'd0, 1'b0};
        tbl[5]  = '{4'd1,  4'd8,  2'd0, 1'b0};
        tbl[6]  = '{4'd15, 4'd8,  2'd0, 1'b1};
        tbl[7]  = '{4'd0,  4'd3,  2'd0, 1'b1};
        tbl[8]  = '{4'd5,  4'd0,  2'd0, 1'b1};
        tbl[9]  = '{4'd9,  4'd15, 2'd0, 1'b1};
        tbl[10] = '{4'd6,  4'd7,  2'd0, 1'b0};
        tbl[11] = '{4'd0,  4'd0,  2'd0, 1'b1};

        reset = 1'b1; start = 1'b0; ack = 1'b0;
        turn_left = '0; turn_right = '0; disp_x = '0; disp_y = '0;
        repeat (2) @(negedge board_clk);
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_alive", 32'(alive), 0);
        chk("rst_heads", {head_x, head_y}, 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_misc", {step_pulse, draw, winner, disp_owner, disp_wall}, 0);
        reset = 1'b0;
        @(negedge board_clk);

        // Round 1: straight run ends in a head swap.
        pulse(0);
        n = 0;
        while (state === ST_CLEAR && n < 1000) begin
            n++;
            @(negedge board_clk);
        end
        chk("clear_len", n, 256);
        chk("ready_state", 32'(state), 32'(ST_READY));
        chk("ready_hx", 32'(head_x), 32'h0D2);
        chk("ready_hy", 32'(head_y), 32'h088);
        chk("ready_alive", 32'(alive), 3);
        pulse(0);
        chk("run_state", 32'(state), 32'(ST_RUN));
        for (int s = 1; s <= 5; s++) wait_step("r1_step", n);
        chk("step_period", n, 16);
        chk("r1_s5_hx", 32'(head_x), 32'h087);
        chk("r1_s5_alive", 32'(alive), 3);
        chk("r1_s5_state", 32'(state), 32'(ST_RUN));
        wait_step("r1_step6", n);
        chk("swap_alive", 32'(alive), 0);
        chk("swap_draw", 32'(draw), 1);
        chk("swap_state", 32'(state), 32'(ST_ROUND));
        chk("swap_score", 32'(score), 0);
        chk("swap_frozen", 32'(head_x), 32'h087);
        for (int i = 0; i < 12; i++) begin
            disp_x = tbl[i].x;
            disp_y = tbl[i].y;
            @(negedge board_clk);
            chk($sformatf("disp(%0d,%0d)", tbl[i].x, tbl[i].y),
                {disp_owner, disp_wall}, {tbl[i].owner, tbl[i].wall});
        end

        // Round 2: p0 turns north and hits the top border on step 8.
        pulse(1);
        chk("ack_clear", 32'(state), 32'(ST_CLEAR));
        wait_state(ST_READY, "r2_ready");
        pulse(0);
        turn_left = 2'b01;
        @(negedge board_clk);
        turn_left = '0;
        for (int s = 1; s <= 7; s++) wait_step("r2_step", n);
        chk("r2_s7_p0", {head_x[3:0], head_y[3:0]}, {4'd2, 4'd1});
        wait_step("r2_step8", n);
        chk("r2_alive", 32'(alive), 2);
        chk("r2_winner", {draw, winner}, {1'b0, 1'b1});
        chk("r2_score", 32'(score), 32'h10);
        chk("r2_state", 32'(state), 32'(ST_ROUND));
        chk("r2_p1x", 32'(head_x[7:4]), 5);

        // Round 3: conflicting turns cancel; display latency; p1 takes the match.
        pulse(1);
        wait_state(ST_READY, "r3_ready");
        disp_x = 4'd5;
        disp_y = 4'd5;
        pulse(0);
        turn_left  = 2'b10;
        turn_right = 2'b10;
        @(negedge board_clk);
        turn_left  = '0;
        turn_right = '0;
        wait_step("r3_step1", n);
        chk("r3_p1_nturn", {head_x[7:4], head_y[7:4]}, {4'd12, 4'd8});
        chk("r3_p0", {head_x[3:0], head_y[3:0]}, {4'd3, 4'd8});
        chk("disp_pre", 32'(disp_owner), 0);
        disp_x = 4'd2;
        disp_y = 4'd8;
        #1;
        chk("disp_hold", 32'(disp_owner), 0);
        turn_left = 2'b01;
        @(negedge board_clk);
        turn_left = '0;
        chk("disp_lat1", 32'(disp_owner), 1);
        for (int s = 2; s <= 8; s++) wait_step("r3_step", n);
        chk("r3_s8_p0", {head_x[3:0], head_y[3:0]}, {4'd3, 4'd1});
        wait_step("r3_step9", n);
        chk("match_alive", 32'(alive), 2);
        chk("match_score", 32'(score), 32'h20);
        chk("match_state", 32'(state), 32'(ST_MATCH));
        chk("match_p1x", 32'(head_x[7:4]), 4);
        pulse(0);
        chk("match_start_ign", 32'(state), 32'(ST_MATCH));
        pulse(1);
        chk("match_ack_score", 32'(score), 0);
        chk("match_ack_state", 32'(state), 32'(ST_CLEAR));

        // Async reset in the middle of a step.
        wait_state(ST_READY, "r4_ready");
        pulse(0);
        wait_step("r4_step1", n);
        repeat (12) @(negedge board_clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", 32'(state), 32'(ST_IDLE));
        chk("async_alive", 32'(alive), 0);
        chk("async_pulse", {step_pulse, head_x}, 0);
        @(negedge board_clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
